intv_sdram_port_bridge: RTL

- Sits between data_io/intv_core and a single port (rom or cart) of sdram_amr.
- Replaces the inline toggle-request logic with a buffered bridge.
- Download bytes are queued in a small FIFO, and ioctl_wait applies back-pressure.
- Core read strobes become toggle requests, and the returned word is latched with a one-cycle valid pulse.

---
 rtl/intv_sdram_port_bridge.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/intv_sdram_port_bridge.sv
// Bridge between the ioctl download path / core read strobes and one
// toggle-handshake port of sdram_amr. Download bytes go through a small
// FIFO; core reads are queued one deep (newest address wins).
//
// Handshake: a request is launched by toggling sdr_req with sdr_addr,
// sdr_din and sdr_we already stable. It is complete on the first clock edge
// where sdr_ack == sdr_req. Those outputs stay unchanged until then. A new
// request is never launched while sdr_ack != sdr_req. This also absorbs a
// stale ack left over from before a reset.
module intv_sdram_port_bridge #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 22
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              overflow,
  input  logic              rd_stb,
  input  logic [15:0]       rd_addr,
  output logic [15:0]       rd_data,
  output logic              rd_valid,
  output logic              idle,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic [7:0]        sdr_din,
  output logic              sdr_we,
  output logic              sdr_req,
  input  logic              sdr_ack,
  input  logic [15:0]       sdr_dout,
  output logic [1:0]        dbg_state
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + 8;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] WAIT_C  = CW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_BUSY = 2'd1,
    S_RD_BUSY = 2'd2
  } state_t;

  state_t            state_q;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ioctl_wait_q, overflow_q, pending_q, idle_q, rd_valid_q;
  logic              sdr_we_q, sdr_req_q;
  logic [15:0]       rd_addr_q, rd_data_q;
  logic [ADDR_W-1:0] sdr_addr_q;
  logic [7:0]        sdr_din_q;
  logic              full, empty, push, pop, ack_match, issue_rd, stb_take;
  logic [EW-1:0]     head;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^ioctl_addr;

  assign full      = (cnt_q == DEPTH_C);
  assign empty     = (cnt_q == '0);
  assign ack_match = (sdr_ack == sdr_req_q);
  assign push      = ioctl_wr & download & ~full;
  // Writes win: a read is only launched once the FIFO has fully drained.
  assign pop       = (state_q == S_IDLE) & ~empty & ack_match;
  assign issue_rd  = (state_q == S_IDLE) & empty & ack_match & pending_q & ~download;
  assign stb_take  = rd_stb & ~download;
  assign head      = mem_q[rd_ptr_q];

  // Occupancy after this edge, used for the registered back-pressure.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  // FIFO storage: {byte address, data byte} per entry.
  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_ptr_q] <= {ioctl_addr[ADDR_W-1:0], ioctl_dout};
  end

  // FIFO pointers, count, back-pressure and sticky overflow.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      ioctl_wait_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q        <= cnt_d;
      // Raised one entry early so a strobe already in flight still fits.
      ioctl_wait_q <= (cnt_d >= WAIT_C);
      if (ioctl_wr && download && full) overflow_q <= 1'b1;
    end
  end

  // Request sequencer with registered SDRAM-side outputs and read capture.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      sdr_addr_q <= '0;
      sdr_din_q  <= '0;
      sdr_we_q   <= 1'b0;
      sdr_req_q  <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      pending_q  <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      rd_valid_q <= 1'b0;
      // A strobe landing on the same edge a read launches queues a new read.
      if (stb_take) begin
        rd_addr_q <= rd_addr;
        pending_q <= 1'b1;
      end else if (issue_rd) begin
        pending_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            sdr_addr_q <= head[EW-1:8];
            sdr_din_q  <= head[7:0];
            sdr_we_q   <= 1'b1;
            sdr_req_q  <= ~sdr_req_q;
            state_q    <= S_WR_BUSY;
          end else if (issue_rd) begin
            sdr_addr_q <= ADDR_W'({rd_addr_q, 1'b0});
            sdr_we_q   <= 1'b0;
            sdr_req_q  <= ~sdr_req_q;
            state_q    <= S_RD_BUSY;
          end
        end
        S_WR_BUSY: begin
          if (ack_match) state_q <= S_IDLE;
        end
        S_RD_BUSY: begin
          if (ack_match) begin
            rd_data_q  <= sdr_dout;
            rd_valid_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      idle_q <= (state_q == S_IDLE) & empty & ~pending_q;
    end
  end

  assign ioctl_wait = ioctl_wait_q;
  assign overflow   = overflow_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign idle       = idle_q;
  assign sdr_addr   = sdr_addr_q;
  assign sdr_din    = sdr_din_q;
  assign sdr_we     = sdr_we_q;
  assign sdr_req    = sdr_req_q;
  assign dbg_state  = state_q;

endmodule
